// File: rtl/note_tone_gen.sv
// Square-wave tone generator: one-word note buffer feeding a two-stage
// (note x octave) down-counter whose combined wrap toggles the speaker.
module note_tone_gen (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_octave,
   input  logic [3:0] in_note,
   output logic       speaker,
   output logic       playing
);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t     state_reg, state_next;
   logic       pend_valid_reg, pend_valid_next;
   logic       pend_rest_reg, pend_rest_next;
   logic [8:0] pend_div_reg, pend_div_next;
   logic [7:0] pend_oct_reg, pend_oct_next;
   logic [8:0] div_reg, div_next;
   logic [7:0] oct_reload_reg, oct_reload_next;
   logic [8:0] note_cnt_reg, note_cnt_next;
   logic [7:0] oct_cnt_reg, oct_cnt_next;
   logic       speaker_reg, speaker_next;

   logic       accept;
   logic [2:0] oct_clamped;
   logic [8:0] in_div;
   logic [7:0] in_oct_reload;

   // Semitone reload values; each stage counts reload+1 cycles per wrap.
   function automatic logic [8:0] note_div(input logic [3:0] n);
      case (n)
         4'd0:    note_div = 9'd511;
         4'd1:    note_div = 9'd482;
         4'd2:    note_div = 9'd455;
         4'd3:    note_div = 9'd430;
         4'd4:    note_div = 9'd405;
         4'd5:    note_div = 9'd383;
         4'd6:    note_div = 9'd361;
         4'd7:    note_div = 9'd341;
         4'd8:    note_div = 9'd322;
         4'd9:    note_div = 9'd303;
         4'd10:   note_div = 9'd286;
         4'd11:   note_div = 9'd270;
         default: note_div = 9'd0;
      endcase
   endfunction

   assign accept        = in_valid && !pend_valid_reg;
   assign oct_clamped   = (in_octave > 3'd5) ? 3'd5 : in_octave;
   assign in_div        = note_div(in_note);
   assign in_oct_reload = 8'hFF >> oct_clamped;

   assign in_ready = !pend_valid_reg;
   assign playing  = (state_reg == PLAY);
   assign speaker  = speaker_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         pend_valid_reg <= 1'b0;
         pend_rest_reg  <= 1'b0;
         pend_div_reg   <= '0;
         pend_oct_reg   <= '0;
         div_reg        <= '0;
         oct_reload_reg <= '0;
         note_cnt_reg   <= '0;
         oct_cnt_reg    <= '0;
         speaker_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pend_valid_reg <= pend_valid_next;
         pend_rest_reg  <= pend_rest_next;
         pend_div_reg   <= pend_div_next;
         pend_oct_reg   <= pend_oct_next;
         div_reg        <= div_next;
         oct_reload_reg <= oct_reload_next;
         note_cnt_reg   <= note_cnt_next;
         oct_cnt_reg    <= oct_cnt_next;
         speaker_reg    <= speaker_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      pend_valid_next = pend_valid_reg;
      pend_rest_next  = pend_rest_reg;
      pend_div_next   = pend_div_reg;
      pend_oct_next   = pend_oct_reg;
      div_next        = div_reg;
      oct_reload_next = oct_reload_reg;
      note_cnt_next   = note_cnt_reg;
      oct_cnt_next    = oct_cnt_reg;
      speaker_next    = speaker_reg;

      case (state_reg)
         IDLE: begin
            if (pend_valid_reg) begin
               pend_valid_next = 1'b0;
               if (!pend_rest_reg) begin
                  state_next      = PLAY;
                  div_next        = pend_div_reg;
                  oct_reload_next = pend_oct_reg;
                  note_cnt_next   = pend_div_reg;
                  oct_cnt_next    = pend_oct_reg;
                  speaker_next    = 1'b0;
               end
            end
         end
         PLAY: begin
            if (note_cnt_reg != 9'd0) begin
               note_cnt_next = note_cnt_reg - 9'd1;
            end else if (oct_cnt_reg != 8'd0) begin
               note_cnt_next = div_reg;
               oct_cnt_next  = oct_cnt_reg - 8'd1;
            end else if (pend_valid_reg && pend_rest_reg) begin
               // Toggle event with a rest waiting: fall silent.
               pend_valid_next = 1'b0;
               state_next      = IDLE;
               speaker_next    = 1'b0;
            end else if (pend_valid_reg) begin
               // Toggle event with a new note waiting: switch on the edge.
               pend_valid_next = 1'b0;
               speaker_next    = !speaker_reg;
               div_next        = pend_div_reg;
               oct_reload_next = pend_oct_reg;
               note_cnt_next   = pend_div_reg;
               oct_cnt_next    = pend_oct_reg;
            end else begin
               speaker_next  = !speaker_reg;
               note_cnt_next = div_reg;
               oct_cnt_next  = oct_reload_reg;
            end
         end
         default: state_next = IDLE;
      endcase

      // Only possible while the buffer is empty, so never collides with a clear.
      if (accept) begin
         pend_valid_next = 1'b1;
         pend_rest_next  = (in_note >= 4'd12);
         pend_div_next   = in_div;
         pend_oct_next   = in_oct_reload;
      end
   end

endmodule

// File: doc/note_tone_gen.md
NOTE_TONE_GEN -- requirements
Module: note_tone_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit; single clock, all state rising-edge.
REQ-002 SHALL have port reset, input, 1 bit; asynchronous, active-high; clears all state.
REQ-003 SHALL have port in_valid, input, 1 bit; upstream note word present.
REQ-004 SHALL have port in_ready, output, 1 bit; block can accept a note word.
REQ-005 SHALL have port in_octave, input, 3 bits; octave 0-5 from the divide-by-12 stage quotient.
REQ-006 SHALL have port in_note, input, 4 bits; semitone 0-11 from the divide-by-12 stage remainder.
REQ-007 SHALL have port speaker, output, 1 bit; square-wave audio output.
REQ-008 SHALL have port playing, output, 1 bit; high while in PLAY state.

Function
REQ-009 SHALL transfer a note word on any rising clk edge where in_valid and in_ready are both high.
REQ-010 SHALL hold one pending word; in_ready = NOT pending_valid, no combinational path from in_valid.
REQ-011 SHALL treat in_note >= 12 as a rest; in_octave > 5 SHALL be clamped to 5.
REQ-012 SHALL use 9-bit note reload D(note), notes 0..11: 511,482,455,430,405,383,361,341,322,303,286,270.
REQ-013 SHALL use 8-bit octave reload R = 255 >> octave.
REQ-014 SHALL have states IDLE and PLAY; in IDLE speaker = 0, playing = 0, counters held.
REQ-015 In PLAY, note counter SHALL decrement each clk; at 0 it reloads D, and octave counter decrements or, if 0, reloads R and raises a toggle event.
REQ-016 Half-period SHALL be exactly (D+1)*(R+1) clk cycles; speaker inverts on each toggle event.
REQ-017 IDLE with pending non-rest word: next cycle SHALL enter PLAY, load both counters, clear pending, speaker stays 0 until first toggle.
REQ-018 IDLE with pending rest word: pending SHALL be cleared next cycle, state stays IDLE.
REQ-019 PLAY with pending word: SHALL apply only at a toggle event; speaker toggles, counters reload with the new D/R, pending clears.
REQ-020 PLAY with pending rest at a toggle event: SHALL enter IDLE, force speaker = 0, clear pending.
REQ-021 in_ready SHALL rise the cycle after pending clears; accept and apply never occur in the same cycle.
REQ-022 Counters SHALL never underflow or wrap outside the reload rule in REQ-015.

Reset
REQ-023 On reset: state IDLE, speaker 0, playing 0, in_ready 1, pending cleared, counters 0.
REQ-024 Reset asserted mid-note SHALL silence speaker immediately and discard pending word; no toggle on release.
REQ-025 First accept SHALL be possible on first clk edge after reset deassertion.

Verification
REQ-026 Reset, send note 0 octave 5 -> playing=1 one cycle later, speaker toggles every 4096 clks.
REQ-027 Send note 11 octave 0 -> half-period 69376 clks, speaker duty exactly 50%.
REQ-028 Playing note 0 oct 5, send note 9 oct 3 mid-half-period -> in_ready low until next toggle, then half-period 304*32 = 9728.
REQ-029 Playing, send note 15 -> at next toggle event playing=0, speaker=0, in_ready=1 one cycle later.
REQ-030 Send octave 7 note 0 -> behaves as octave 5 (4096-clk half-period).
REQ-031 Assert reset mid-note with pending word held -> speaker=0, playing=0, in_ready=1 immediately; pending word never plays.
